// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control unit: sequences IF/ID/EXE/MEM/WB and drives the datapath strobes.
// Optional performance counters (cycle_cnt, instr_cnt) are enabled by defining MULTI_CYCLE_CTRL_PERF_EN.
module multi_cycle_ctrl #(
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            PCWre,
  output logic [1:0]      PcSrc,
  output logic            InsMemRw,
  output logic            IRWre,
  output logic            RegWre,
  output logic            RegDst,
  output logic            ALUSrcA,
  output logic            ALUSrcB,
  output logic            ExtSel,
  output logic [2:0]      ALUOp,
  output logic            mRD,
  output logic            mWR,
  output logic            DBDataSrc,
  output logic [2:0]      state
`ifdef MULTI_CYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     instr_cnt
`endif
);

  localparam logic [OP_W-1:0] OpAdd  = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OpSub  = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OpAddi = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OpOr   = OP_W'(6'b010000);
  localparam logic [OP_W-1:0] OpAnd  = OP_W'(6'b010001);
  localparam logic [OP_W-1:0] OpOri  = OP_W'(6'b010010);
  localparam logic [OP_W-1:0] OpSll  = OP_W'(6'b011000);
  localparam logic [OP_W-1:0] OpSlt  = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OpSw   = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] OpLw   = OP_W'(6'b110001);
  localparam logic [OP_W-1:0] OpBeq  = OP_W'(6'b110100);
  localparam logic [OP_W-1:0] OpJ    = OP_W'(6'b111000);
  localparam logic [OP_W-1:0] OpHalt = OP_W'(6'b111111);

  typedef enum logic [2:0] {
    sIf    = 3'b000,
    sId    = 3'b001,
    sExeLs = 3'b010,
    sMem   = 3'b011,
    sWbLd  = 3'b100,
    sExeBr = 3'b101,
    sExeAl = 3'b110,
    sWbAl  = 3'b111
  } stateT;

  stateT curState, nextState;
  logic  halted, nextHalted;

  // Per-opcode EXE controls; only driven onto the outputs in EXE states.
  logic [2:0] decAluOp;
  logic       decSrcA, decSrcB, decExt, decRType;
  logic       isAlu, isLs, isBr;

  assign state = curState;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curState <= sIf;
      halted   <= 1'b0;
    end else begin
      curState <= nextState;
      halted   <= nextHalted;
    end
  end

  always_comb begin
    decAluOp = 3'b000;
    decSrcA  = 1'b0;
    decSrcB  = 1'b0;
    decExt   = 1'b0;
    decRType = 1'b0;
    isAlu    = 1'b0;
    isLs     = 1'b0;
    isBr     = 1'b0;
    case (op)
      OpAdd:  begin isAlu = 1'b1; decRType = 1'b1; end
      OpSub:  begin isAlu = 1'b1; decRType = 1'b1; decAluOp = 3'b001; end
      OpAddi: begin isAlu = 1'b1; decSrcB = 1'b1; decExt = 1'b1; end
      OpOr:   begin isAlu = 1'b1; decRType = 1'b1; decAluOp = 3'b011; end
      OpAnd:  begin isAlu = 1'b1; decRType = 1'b1; decAluOp = 3'b100; end
      OpOri:  begin isAlu = 1'b1; decSrcB = 1'b1; decAluOp = 3'b011; end
      OpSll:  begin isAlu = 1'b1; decRType = 1'b1; decSrcA = 1'b1; decAluOp = 3'b010; end
      OpSlt:  begin isAlu = 1'b1; decRType = 1'b1; decAluOp = 3'b101; end
      OpSw,
      OpLw:   begin isLs = 1'b1; decSrcB = 1'b1; decExt = 1'b1; end
      OpBeq:  begin isBr = 1'b1; decExt = 1'b1; decAluOp = 3'b001; end
      default: ;
    endcase
  end

  // NOTE: every output and next-state term gets a default first so no latch is inferred.
  always_comb begin
    nextState  = curState;
    nextHalted = halted;
    PCWre      = 1'b0;
    PcSrc      = 2'b00;
    InsMemRw   = 1'b0;
    IRWre      = 1'b0;
    RegWre     = 1'b0;
    RegDst     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 1'b0;
    ExtSel     = 1'b0;
    ALUOp      = 3'b000;
    mRD        = 1'b0;
    mWR        = 1'b0;
    DBDataSrc  = 1'b0;
    case (curState)
      sIf: begin
        InsMemRw  = 1'b1;
        IRWre     = 1'b1;
        nextState = sId;
      end
      sId: begin
        // A halted core parks here with every strobe low until reset.
        if (!halted) begin
          if (isAlu)       nextState = sExeAl;
          else if (isLs)   nextState = sExeLs;
          else if (isBr)   nextState = sExeBr;
          else if (op == OpHalt) nextHalted = 1'b1;
          else begin
            PCWre     = 1'b1;
            PcSrc     = (op == OpJ) ? 2'b10 : 2'b00;
            nextState = sIf;
          end
        end
      end
      sExeAl, sExeLs, sExeBr: begin
        ALUOp   = decAluOp;
        ALUSrcA = decSrcA;
        ALUSrcB = decSrcB;
        ExtSel  = decExt;
        if (curState == sExeAl)      nextState = sWbAl;
        else if (curState == sExeLs) nextState = sMem;
        else begin
          PCWre     = 1'b1;
          PcSrc     = zero ? 2'b01 : 2'b00;
          nextState = sIf;
        end
      end
      sWbAl: begin
        RegWre    = 1'b1;
        RegDst    = decRType;
        PCWre     = 1'b1;
        nextState = sIf;
      end
      sMem: begin
        mRD = (op == OpLw);
        mWR = (op != OpLw);
        if (mem_ready) begin
          if (op == OpLw) nextState = sWbLd;
          else begin
            PCWre     = 1'b1;
            nextState = sIf;
          end
        end
      end
      sWbLd: begin
        RegWre    = 1'b1;
        DBDataSrc = 1'b1;
        PCWre     = 1'b1;
        nextState = sIf;
      end
      default: nextState = sIf;
    endcase
  end

`ifdef MULTI_CYCLE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      if (!halted) cycle_cnt <= cycle_cnt + 32'd1;
      if (PCWre)   instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule
